// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: FSM states and memory access sizes.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE  = 2'b00,
    LSU_BUS   = 2'b01,
    LSU_DONE  = 2'b10,
    LSU_FAULT = 2'b11
  } lsu_state_t;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_size_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store enables/replication, misalignment detect, and load
// extraction with sign/zero extension. Purely combinational.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  mem_size_t   size_i,
  input  logic        uns_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misalign_o,
  output logic [31:0] ldata_o
);

  logic [31:0] lane;

  always_comb begin
    lane       = rdata_i >> {off_i, 3'b000};
    be_o       = 4'b0000;
    wdata_o    = 32'h0;
    misalign_o = 1'b1;  // reserved size encoding is treated as unaligned
    ldata_o    = lane;
    case (size_i)
      MEM_BYTE: begin
        be_o       = 4'b0001 << off_i;
        wdata_o    = {4{wdata_i[7:0]}};
        misalign_o = 1'b0;
        ldata_o    = {{24{~uns_i & lane[7]}}, lane[7:0]};
      end
      MEM_HALF: begin
        be_o       = 4'b0011 << off_i;
        wdata_o    = {2{wdata_i[15:0]}};
        misalign_o = off_i[0];
        ldata_o    = {{16{~uns_i & lane[15]}}, lane[15:0]};
      end
      MEM_WORD: begin
        be_o       = 4'b1111;
        wdata_o    = wdata_i;
        misalign_o = |off_i;
        ldata_o    = lane;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-bus master: accepts an EXEC-stage load/store, runs one req/ack cycle with
// timeout, stalls the control unit meanwhile and returns extended load data.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        re,
  input  logic        we,
  input  logic [2:0]  f3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        done,
  output logic        fault,
  output logic        dbus_req,
  output logic [31:0] dbus_addr,
  output logic        dbus_we,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [31:0]       addr_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [31:0]       load_data_q;

  logic              is_idle;
  mem_size_t         size_sel;
  logic [1:0]        off_sel;
  logic [3:0]        be_al;
  logic [31:0]       wdata_al;
  logic [31:0]       ldata_al;
  logic              misalign;
  logic              req_valid;
  logic              req_illegal;
  logic              accept;

  // In IDLE the aligner looks at the incoming request; afterwards at the latched one.
  assign is_idle  = (state_q == LSU_IDLE);
  assign size_sel = mem_size_t'(is_idle ? f3[1:0] : f3_q[1:0]);
  assign off_sel  = is_idle ? addr[1:0] : addr_q[1:0];

  lsu_lane_align u_align (
    .size_i     (size_sel),
    .uns_i      (f3_q[2]),
    .off_i      (off_sel),
    .wdata_i    (wdata),
    .rdata_i    (dbus_rdata),
    .be_o       (be_al),
    .wdata_o    (wdata_al),
    .misalign_o (misalign),
    .ldata_o    (ldata_al)
  );

  assign req_valid   = start & (re | we);
  assign req_illegal = (re & we) | (f3[1:0] == 2'b11) | (we & f3[2]) | misalign;
  assign accept      = is_idle & req_valid & ~req_illegal;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      LSU_IDLE: begin
        cnt_d = '0;
        if (req_valid) state_d = req_illegal ? LSU_FAULT : LSU_BUS;
      end
      LSU_BUS: begin
        cnt_d = cnt_q + CNT_W'(1);
        // ack on the final wait cycle still completes the access
        if (dbus_ack)              state_d = LSU_DONE;
        else if (cnt_q == CNT_LAST) state_d = LSU_FAULT;
      end
      LSU_DONE:  state_d = LSU_IDLE;
      LSU_FAULT: state_d = LSU_IDLE;
      default:   state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LSU_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q        <= 1'b0;
      f3_q        <= 3'b000;
      addr_q      <= 32'h0;
      be_q        <= 4'b0000;
      wdata_q     <= 32'h0;
      load_data_q <= 32'h0;
    end else begin
      if (accept) begin
        we_q    <= we;
        f3_q    <= f3;
        addr_q  <= addr;
        be_q    <= be_al;
        wdata_q <= wdata_al;
      end
      if (state_q == LSU_BUS && dbus_ack && !we_q) load_data_q <= ldata_al;
    end
  end

  assign stall      = (is_idle & start) | (state_q == LSU_BUS);
  assign done       = (state_q == LSU_DONE);
  assign fault      = (state_q == LSU_FAULT);
  assign dbus_req   = (state_q == LSU_BUS);
  assign dbus_addr  = {addr_q[31:2], 2'b00};
  assign dbus_we    = we_q;
  assign dbus_be    = be_q;
  assign dbus_wdata = wdata_q;
  assign load_data  = load_data_q;

endmodule
